// File: rtl/key_event_pkg.sv
`default_nettype none
// ==========================================================================
// key_event_pkg - event codes, key FSM states and sizing helper | Rev 1.0
// ==========================================================================
package key_event_pkg;

  typedef enum logic [1:0] {
    EVT_SHORT  = 2'b00,
    EVT_LONG   = 2'b01,
    EVT_DOUBLE = 2'b10
  } evt_type_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HOLD   = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4
  } key_state_e;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_fsm.sv
`default_nettype none
// ==========================================================================
// key_event_fsm - per-key edge detect, counter and click classifier | Rev 1.0
// ==========================================================================
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int LONG_CNT   = 50_000_000,
  parameter int DCLICK_WIN = 12_500_000,
  parameter int CNT_W      = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_level,
  output logic       emit,
  output logic [1:0] emit_type
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(DCLICK_WIN - 1);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  evt_type_e        type_q, type_d;
  logic             emit_q, emit_d;
  logic             key_prev_q, key_prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic             press, rls;

  always_comb begin
    // no edges until key_prev has captured a real level after reset
    press      = prev_vld_q & key_prev_q & ~key_level;
    rls        = prev_vld_q & ~key_prev_q & key_level;
    state_d    = state_q;
    cnt_d      = cnt_q;
    type_d     = type_q;
    emit_d     = 1'b0;
    key_prev_d = key_level;
    prev_vld_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        if (rls) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = HOLD;
          emit_d  = 1'b1;
          type_d  = EVT_LONG;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (rls) state_d = IDLE;
      end
      WAIT2: begin
        // a press landing on the expiry cycle still counts as the second click
        if (press) begin
          state_d = PRESS2;
        end else if (cnt_q == WIN_LAST) begin
          state_d = IDLE;
          emit_d  = 1'b1;
          type_d  = EVT_SHORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESS2: begin
        if (rls) begin
          state_d = IDLE;
          emit_d  = 1'b1;
          type_d  = EVT_DOUBLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      type_q     <= EVT_SHORT;
      emit_q     <= 1'b0;
      key_prev_q <= 1'b1;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      type_q     <= type_d;
      emit_q     <= emit_d;
      key_prev_q <= key_prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign emit      = emit_q;
  assign emit_type = type_q;

endmodule
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ==========================================================================
// key_event_ctrl - key click classifiers merged by RR arbiter to one stream | Rev 1.0
// ==========================================================================
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int KEY_NUM    = 4,
  parameter int LONG_CNT   = 50_000_000,
  parameter int DCLICK_WIN = 12_500_000,
  parameter int ID_W       = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_level,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_key,
  output logic [1:0]         evt_type,
  output logic               evt_drop
);

  localparam int CNT_W = cnt_width(LONG_CNT, DCLICK_WIN);

  logic [KEY_NUM-1:0] emit_w;
  logic [1:0]         emit_type_w [KEY_NUM];

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    key_event_fsm #(
      .LONG_CNT   (LONG_CNT),
      .DCLICK_WIN (DCLICK_WIN),
      .CNT_W      (CNT_W)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .key_level (key_level[g]),
      .emit      (emit_w[g]),
      .emit_type (emit_type_w[g])
    );
  end

  logic [KEY_NUM-1:0] pend_v_q, pend_v_d;
  logic [1:0]         pend_t_q [KEY_NUM];
  logic [1:0]         pend_t_d [KEY_NUM];
  logic [ID_W-1:0]    rr_q, rr_d;
  logic               evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]    evt_key_q, evt_key_d;
  logic [1:0]         evt_type_q, evt_type_d;
  logic               evt_drop_q, evt_drop_d;

  logic               load;
  logic               found;
  logic [ID_W-1:0]    win;
  logic [KEY_NUM-1:0] grant;
  int                 idx;

  // rotating search: first pending slot at or after the RR pointer
  always_comb begin
    load  = ~evt_valid_q | evt_ready;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < KEY_NUM; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= KEY_NUM) idx = idx - KEY_NUM;
      if (!found && pend_v_q[ID_W'(idx)]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
    for (int k = 0; k < KEY_NUM; k++) begin
      grant[k] = load & found & (win == ID_W'(k));
    end
  end

  always_comb begin
    pend_v_d    = pend_v_q;
    pend_t_d    = pend_t_q;
    evt_drop_d  = 1'b0;
    evt_valid_d = evt_valid_q;
    evt_key_d   = evt_key_q;
    evt_type_d  = evt_type_q;
    rr_d        = rr_q;
    for (int k = 0; k < KEY_NUM; k++) begin
      if (emit_w[k]) begin
        // a slot being granted this cycle frees up in time for the new event
        if (pend_v_q[k] && !grant[k]) begin
          evt_drop_d = 1'b1;
        end else begin
          pend_v_d[k] = 1'b1;
          pend_t_d[k] = emit_type_w[k];
        end
      end else if (grant[k]) begin
        pend_v_d[k] = 1'b0;
      end
    end
    if (load) begin
      evt_valid_d = found;
      if (found) begin
        evt_key_d  = win;
        evt_type_d = pend_t_q[win];
        rr_d       = (win == ID_W'(KEY_NUM - 1)) ? '0 : win + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q    <= '0;
      for (int k = 0; k < KEY_NUM; k++) pend_t_q[k] <= 2'b00;
      rr_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_type_q  <= 2'b00;
      evt_drop_q  <= 1'b0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_t_q    <= pend_t_d;
      rr_q        <= rr_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
      evt_type_q  <= evt_type_d;
      evt_drop_q  <= evt_drop_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_key   = evt_key_q;
  assign evt_type  = evt_type_q;
  assign evt_drop  = evt_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_key_event_ctrl - directed and random key stimulus against a timing model | Rev 1.0
// ==========================================================================
module tb_key_event_ctrl;

  localparam int N   = 4;
  localparam int LC  = 100;
  localparam int DW  = 40;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   key_level = '1;
  logic           evt_ready = 1'b1;
  logic           evt_valid;
  logic [IDW-1:0] evt_key;
  logic [1:0]     evt_type;
  logic           evt_drop;

  key_event_ctrl #(
    .KEY_NUM    (N),
    .LONG_CNT   (LC),
    .DCLICK_WIN (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_level (key_level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_key   (evt_key),
    .evt_type  (evt_type),
    .evt_drop  (evt_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cnt = 0, acc_key = -1, acc_type = -1, drop_cnt = 0;

  // Reference: per key a mode plus an absolute deadline (edge index) for LONG / window expiry.
  // mode 0 idle, 1 first press down, 2 held past LONG, 3 awaiting 2nd press, 4 second press down
  int md [N];
  int dl [N];
  bit kp [N];
  bit pvld;
  bit em [N];
  int et [N];
  bit sv [N];
  int st [N];
  int rr, ok_m, ot_m;
  bit ov_m, od_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic model_step(input logic [N-1:0] lvl, input bit rdy, input bit r, input int e);
    bit load;
    int win;
    bit press, rel;
    bit nem [N];
    int net [N];
    bit nsv [N];
    int nst [N];
    if (r) begin
      for (int k = 0; k < N; k++) begin
        md[k] = 0; dl[k] = 0; kp[k] = 1'b1; em[k] = 1'b0; et[k] = 0; sv[k] = 1'b0; st[k] = 0;
      end
      pvld = 1'b0; rr = 0; ok_m = 0; ot_m = 0; ov_m = 1'b0; od_m = 1'b0;
      return;
    end
    load = !ov_m || rdy;
    win  = -1;
    if (load)
      for (int i = 0; i < N; i++)
        if (win < 0 && sv[(rr + i) % N]) win = (rr + i) % N;
    od_m = 1'b0;
    for (int k = 0; k < N; k++) begin
      nsv[k] = sv[k];
      nst[k] = st[k];
      if (em[k]) begin
        if (sv[k] && win != k) od_m = 1'b1;
        else begin nsv[k] = 1'b1; nst[k] = et[k]; end
      end else if (win == k) nsv[k] = 1'b0;
    end
    if (load) begin
      ov_m = (win >= 0);
      if (win >= 0) begin ok_m = win; ot_m = st[win]; rr = (win + 1) % N; end
    end
    for (int k = 0; k < N; k++) begin
      press  = pvld && kp[k] && !lvl[k];
      rel    = pvld && !kp[k] && lvl[k];
      nem[k] = 1'b0;
      net[k] = et[k];
      case (md[k])
        0: if (press) begin md[k] = 1; dl[k] = e + LC; end
        1: if (rel) begin md[k] = 3; dl[k] = e + DW; end
           else if (e == dl[k]) begin md[k] = 2; nem[k] = 1'b1; net[k] = 1; end
        2: if (rel) md[k] = 0;
        3: if (press) md[k] = 4;
           else if (e == dl[k]) begin md[k] = 0; nem[k] = 1'b1; net[k] = 0; end
        4: if (rel) begin md[k] = 0; nem[k] = 1'b1; net[k] = 2; end
        default: md[k] = 0;
      endcase
      kp[k] = lvl[k];
    end
    pvld = 1'b1;
    em = nem; et = net; sv = nsv; st = nst;
  endtask

  task automatic tick();
    logic [N-1:0] lvl = key_level;
    bit rdy = evt_ready;
    bit r   = rst;
    if (!r && evt_valid && rdy) begin
      acc_cnt++; acc_key = int'(evt_key); acc_type = int'(evt_type);
    end
    @(posedge clk);
    model_step(lvl, rdy, r, cyc);
    cyc++;
    #1;
    check_eq("valid", evt_valid, ov_m);
    if (ov_m) begin
      check_eq("key", evt_key, ok_m);
      check_eq("type", evt_type, ot_m);
    end
    check_eq("drop", evt_drop, od_m);
    check_eq("type_rsv", evt_type == 2'b11, 0);
    if (evt_drop) drop_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; run(2); rst = 1'b0; run(1);
  endtask

  int a0, d0;
  int tmr [N];

  initial begin
    #1;
    run(3);
    rst = 1'b0;
    run(1);
    check_eq("rst_valid", evt_valid, 0);
    check_eq("rst_key", evt_key, 0);
    check_eq("rst_type", evt_type, 0);
    check_eq("rst_drop", evt_drop, 0);

    // single short click
    a0 = acc_cnt;
    key_level[0] = 1'b0; run(10); key_level[0] = 1'b1; run(80);
    check_eq("t1_count", acc_cnt - a0, 1);
    check_eq("t1_key", acc_key, 0);
    check_eq("t1_type", acc_type, 0);

    // long hold, nothing on release
    a0 = acc_cnt;
    key_level[1] = 1'b0; run(150); key_level[1] = 1'b1; run(60);
    check_eq("t2_count", acc_cnt - a0, 1);
    check_eq("t2_key", acc_key, 1);
    check_eq("t2_type", acc_type, 1);

    // double click
    a0 = acc_cnt;
    key_level[2] = 1'b0; run(10); key_level[2] = 1'b1; run(10);
    key_level[2] = 1'b0; run(10); key_level[2] = 1'b1; run(60);
    check_eq("t3_count", acc_cnt - a0, 1);
    check_eq("t3_key", acc_key, 2);
    check_eq("t3_type", acc_type, 2);

    // simultaneous emits under backpressure
    do_reset();
    a0 = acc_cnt;
    key_level[1] = 1'b0; key_level[3] = 1'b0; run(10);
    key_level[1] = 1'b1; key_level[3] = 1'b1; evt_ready = 1'b0; run(50);
    check_eq("t4_held_valid", evt_valid, 1);
    check_eq("t4_held_key", evt_key, 1);
    evt_ready = 1'b1; run(5);
    check_eq("t4_count", acc_cnt - a0, 2);
    check_eq("t4_last_key", acc_key, 3);

    // full slot drops the third event
    a0 = acc_cnt; d0 = drop_cnt;
    evt_ready = 1'b0;
    key_level[0] = 1'b0; run(10); key_level[0] = 1'b1; run(60);
    key_level[0] = 1'b0; run(110); key_level[0] = 1'b1; run(10);
    key_level[0] = 1'b0; run(10); key_level[0] = 1'b1; run(60);
    evt_ready = 1'b1; run(5);
    check_eq("t5_count", acc_cnt - a0, 2);
    check_eq("t5_drops", drop_cnt - d0, 1);
    check_eq("t5_last_type", acc_type, 1);

    // reset while a key is held down
    a0 = acc_cnt;
    key_level[0] = 1'b0; run(20);
    rst = 1'b1; run(2); rst = 1'b0;
    run(150);
    key_level[0] = 1'b1; run(60);
    check_eq("t6_silent", acc_cnt - a0, 0);
    key_level[0] = 1'b0; run(10); key_level[0] = 1'b1; run(60);
    check_eq("t6_count", acc_cnt - a0, 1);
    check_eq("t6_type", acc_type, 0);

    // random traffic
    for (int k = 0; k < N; k++) tmr[k] = $urandom_range(1, 50);
    for (int c = 0; c < 6000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (tmr[k] == 0) begin
          key_level[k] = ~key_level[k];
          if (key_level[k] == 1'b0)
            case ($urandom_range(0, 2))
              0:       tmr[k] = $urandom_range(2, 30);
              1:       tmr[k] = $urandom_range(95, 105);
              default: tmr[k] = $urandom_range(106, 140);
            endcase
          else
            tmr[k] = $urandom_range(2, 60);
        end else begin
          tmr[k]--;
        end
      end
      evt_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 2999) == 0) rst = 1'b1;
      else rst = 1'b0;
      tick();
    end
    rst = 1'b0;
    evt_ready = 1'b1;
    key_level = '1;
    run(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
